// File: rtl/neuron_dot_product_seq_pkg.sv
// Shared definitions for the sequential neuron dot-product block.
// Contents: geometry/format parameters, FSM state encoding, saturation
// result type and the saturate() helper used by the datapath.
package neuron_dot_product_seq_pkg;

  localparam int N_IN      = 28;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Largest / smallest DATA_W values, sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] y;
  } sat_res_t;

  // Clamp a wide signed value into DATA_W, flagging when clamping occurred.
  function automatic sat_res_t saturate(input logic signed [ACC_W-1:0] v);
    sat_res_t res;
    if (v > SAT_MAX) begin
      res.sat = 1'b1;
      res.y   = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      res.sat = 1'b1;
      res.y   = SAT_MIN[DATA_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.y   = v[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_dot_product_seq_if.sv
// Bus bundle between the neuron and its environment: start/bias control,
// the weight BRAM and activation buffer read ports, and the result.
// Modports: slave = neuron, master = environment (memories + controller).
interface neuron_dot_product_seq_if;
  import neuron_dot_product_seq_pkg::*;

  logic              START;
  logic [DATA_W-1:0] BIAS;
  logic [ADDR_W-1:0] W_ADDR;
  logic              W_EN;
  logic              W_WE;
  logic [DATA_W-1:0] W_DO;
  logic [ADDR_W-1:0] X_ADDR;
  logic              X_EN;
  logic [DATA_W-1:0] X_DO;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] Y;
  logic              SAT;

  modport slave (
    input  START, BIAS, W_DO, X_DO,
    output W_ADDR, W_EN, W_WE, X_ADDR, X_EN, BUSY, DONE, Y, SAT
  );

  modport master (
    output START, BIAS, W_DO, X_DO,
    input  W_ADDR, W_EN, W_WE, X_ADDR, X_EN, BUSY, DONE, Y, SAT
  );
endinterface

// File: rtl/neuron_dot_product_seq_mac_dp.sv
// neuron_mac_dp: signed MAC datapath of the neuron.
// Ports: clk, rst_n (async active-low); load_i/bias_i preload the
// accumulator with the bias; acc_en_i adds w_i*x_i; fin_i rescales,
// saturates (optionally ReLUs) and registers the result on y_o/sat_o.
// Optional feature macro: NEURON_RELU_EN (negative results forced to 0).
module neuron_mac_dp
  import neuron_dot_product_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] bias_i,
  input  logic              acc_en_i,
  input  logic              fin_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] x_i,
  output logic [DATA_W-1:0] y_o,
  output logic              sat_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [DATA_W-1:0]   y_q, y_d;
  logic                       sat_q, sat_d;
  logic signed [2*DATA_W-1:0] w_ext_s, x_ext_s, prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s, shr_s;
  sat_res_t                   sat_res_s;
  logic        [DATA_W-1:0]   y_post_s;

  // Operands widened first so the product is computed at full width.
  assign w_ext_s    = {{DATA_W{w_i[DATA_W-1]}}, w_i};
  assign x_ext_s    = {{DATA_W{x_i[DATA_W-1]}}, x_i};
  assign prod_s     = w_ext_s * x_ext_s;
  assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
  // Arithmetic shift: truncation toward -inf.
  assign shr_s      = acc_q >>> FRAC_BITS;
  assign sat_res_s  = saturate(shr_s);

  // Accumulator and result next-state logic.
  always_comb begin
    acc_d = acc_q;
    y_d   = y_q;
    sat_d = sat_q;
    // Bias is aligned to the product's 2*FRAC_BITS fractional point.
    if (load_i) begin
      acc_d = {{(ACC_W-DATA_W-FRAC_BITS){bias_i[DATA_W-1]}}, bias_i, {FRAC_BITS{1'b0}}};
    end else if (acc_en_i) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end
`ifdef NEURON_RELU_EN
    if (sat_res_s.y[DATA_W-1]) begin
      y_post_s = {DATA_W{1'b0}};
    end else begin
      y_post_s = sat_res_s.y;
    end
`else
    y_post_s = sat_res_s.y;
`endif
    // SAT reflects clamping before any ReLU.
    if (fin_i) begin
      y_d   = y_post_s;
      sat_d = sat_res_s.sat;
    end else begin
      y_d   = y_q;
      sat_d = sat_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {ACC_W{1'b0}};
      y_q   <= {DATA_W{1'b0}};
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/neuron_dot_product_seq.sv
// neuron_dot_product_seq: sequential signed fixed-point dot product of one
// neuron (weights x activations + bias), rescaled and saturated.
// Ports: CLK, RST_N (async active-low), bus (slave modport): START/BIAS
// in, weight/activation read ports (1-cycle latency, falling-edge read),
// BUSY/DONE status and Y/SAT result.
// Optional feature macro: NEURON_RELU_EN (see neuron_mac_dp).
module neuron_dot_product_seq
  import neuron_dot_product_seq_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RST_N,
  neuron_dot_product_seq_if.slave      bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_s, acc_en_s, fin_s;

  assign load_s   = (state_q == ST_IDLE) && bus.START;
  // vld_q marks that the address issued on the previous edge returns data now.
  assign acc_en_s = (state_q == ST_FETCH) && vld_q;
  assign fin_s    = (state_q == ST_FINISH);

  // FSM and address counter next-state logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    en_d    = en_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_FETCH;
          addr_d  = {ADDR_W{1'b0}};
          en_d    = 1'b1;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Address holds at the last entry once the sweep ends.
        if (addr_q == LAST_ADDR) begin
          en_d    = 1'b0;
          vld_d   = 1'b0;
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  neuron_mac_dp u_mac_dp (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load_i   (load_s),
    .bias_i   (bus.BIAS),
    .acc_en_i (acc_en_s),
    .fin_i    (fin_s),
    .w_i      (bus.W_DO),
    .x_i      (bus.X_DO),
    .y_o      (bus.Y),
    .sat_o    (bus.SAT)
  );

  // Weight and activation buffers are swept in lockstep.
  assign bus.W_ADDR = addr_q;
  assign bus.W_EN   = en_q;
  assign bus.W_WE   = 1'b0;
  assign bus.X_ADDR = addr_q;
  assign bus.X_EN   = en_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_neuron_dot_product_seq.sv
// Directed self-checking bench for neuron_dot_product_seq. The weight BRAM
// and activation buffer are modelled with a falling-edge read, 1-cycle latency.
module tb_neuron_dot_product_seq;
  import neuron_dot_product_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] wmem [28];
  logic [15:0] xmem [28];

  neuron_dot_product_seq_if bus ();

  neuron_dot_product_seq dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory models: read on the falling edge.
  always @(negedge clk) begin
    if (bus.W_EN === 1'b1) bus.W_DO = wmem[bus.W_ADDR];
    if (bus.X_EN === 1'b1) bus.X_DO = xmem[bus.X_ADDR];
  end

  task automatic fill(input int mode, input logic [15:0] w, input logic [15:0] x);
    for (int i = 0; i < 28; i++) begin
      wmem[i] = (mode == 1) ? 16'(i * 256) : w;
      xmem[i] = x;
    end
  endtask

  // Start one run (BIAS scrambled after the START edge), wait for DONE.
  task automatic do_run(input logic [15:0] bias, output int cyc);
    @(negedge clk);
    bus.START = 1'b1;
    bus.BIAS  = bias;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.BIAS  = ~bias;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.DONE === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.W_ADDR, bus.X_ADDR, bus.W_EN, bus.X_EN, bus.W_WE, bus.BUSY, bus.DONE, bus.Y, bus.SAT} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%0d en=%b busy=%b done=%b y=%h sat=%b, expected all 0",
               bus.W_ADDR, bus.W_EN, bus.BUSY, bus.DONE, bus.Y, bus.SAT);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    int          cyc;
    logic [15:0] w, x, b, ey;
    logic        es;
    int          mode;
    for (int v = 0; v < 8; v++) begin
      mode = 0;
      case (v)
        0: begin w = 16'h0100; x = 16'h0100; b = 16'h0000; ey = 16'h1C00; es = 1'b0; end
        1: begin w = 16'h7FFF; x = 16'h7FFF; b = 16'h7FFF; ey = 16'h7FFF; es = 1'b1; end
        2: begin w = 16'h8000; x = 16'h7FFF; b = 16'h0000; ey = 16'h8000; es = 1'b1; end
        3: begin mode = 1; w = 16'h0000; x = 16'h0080; b = 16'hFF00; ey = 16'h7FFF; es = 1'b1; end
        4: begin mode = 1; w = 16'h0000; x = 16'h0008; b = 16'hFF00; ey = 16'h0AD0; es = 1'b0; end
        5: begin w = 16'h0001; x = 16'hFFFF; b = 16'h0000; ey = 16'hFFFF; es = 1'b0; end
        6: begin w = 16'h0000; x = 16'h1234; b = 16'h7FFF; ey = 16'h7FFF; es = 1'b0; end
        default: begin w = 16'h0000; x = 16'h1234; b = 16'h8000; ey = 16'h8000; es = 1'b0; end
      endcase
`ifdef NEURON_RELU_EN
      if (ey[15]) ey = 16'h0000;
`endif
      fill(mode, w, x);
      do_run(b, cyc);
      n_cmp++;
      if (cyc !== 29) begin
        n_err++;
        $display("FAIL vec%0d_latency: got %0d cycles, expected 29", v, cyc);
      end
      n_cmp++;
      if (bus.Y !== ey || bus.SAT !== es) begin
        n_err++;
        $display("FAIL vec%0d_result: got Y=%h SAT=%b, expected Y=%h SAT=%b", v, bus.Y, bus.SAT, ey, es);
      end
      n_cmp++;
      if (bus.BUSY !== 1'b0) begin
        n_err++;
        $display("FAIL vec%0d_busy_at_done: got %b, expected 0", v, bus.BUSY);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.DONE !== 1'b0 || bus.Y !== ey) begin
        n_err++;
        $display("FAIL vec%0d_done_pulse: got DONE=%b Y=%h, expected DONE=0 Y=%h", v, bus.DONE, bus.Y, ey);
      end
    end
  endtask

  task automatic test_addr_sweep();
    fill(1, 16'h0000, 16'h0080);
    @(negedge clk);
    bus.START = 1'b1;
    bus.BIAS  = 16'hFF00;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    for (int k = 0; k <= 27; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if (bus.W_ADDR !== 5'(k) || bus.X_ADDR !== bus.W_ADDR || bus.W_EN !== 1'b1 ||
          bus.X_EN !== 1'b1 || bus.W_WE !== 1'b0 || bus.BUSY !== 1'b1) begin
        n_err++;
        $display("FAIL addr_k%0d: got W_ADDR=%0d X_ADDR=%0d W_EN=%b X_EN=%b WE=%b BUSY=%b, expected addr %0d en 1 we 0 busy 1",
                 k, bus.W_ADDR, bus.X_ADDR, bus.W_EN, bus.X_EN, bus.W_WE, bus.BUSY, k);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.W_EN !== 1'b0 || bus.X_EN !== 1'b0 || bus.W_ADDR !== 5'd27 || bus.X_ADDR !== 5'd27) begin
      n_err++;
      $display("FAIL addr_hold: got W_EN=%b W_ADDR=%0d X_ADDR=%0d, expected 0/27/27", bus.W_EN, bus.W_ADDR, bus.X_ADDR);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.DONE !== 1'b1 || bus.Y !== 16'h7FFF || bus.SAT !== 1'b1) begin
      n_err++;
      $display("FAIL addr_result: got DONE=%b Y=%h SAT=%b, expected 1/7fff/1", bus.DONE, bus.Y, bus.SAT);
    end
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    int first  = -1;
    fill(1, 16'h0000, 16'h0008);
    @(negedge clk);
    bus.START = 1'b1;
    bus.BIAS  = 16'hFF00;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.BIAS  = 16'h4000;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk);
      #1;
      bus.START = (i == 10) ? 1'b1 : 1'b0;
      if (bus.DONE === 1'b1) begin
        n_done++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (n_done !== 1 || first !== 29) begin
      n_err++;
      $display("FAIL start_ignored_done: got %0d DONEs first at %0d, expected 1 at 29", n_done, first);
    end
    n_cmp++;
    if (bus.Y !== 16'h0AD0 || bus.SAT !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored_result: got Y=%h SAT=%b, expected 0ad0/0", bus.Y, bus.SAT);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    int extra = 0;
    fill(0, 16'h0100, 16'h0100);
    @(negedge clk);
    bus.START = 1'b1;
    bus.BIAS  = 16'h0000;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.DONE === 1'b1) begin
        if (d1 < 0) begin
          d1 = i;
        end else if (d2 < 0) begin
          d2 = i;
          bus.START = 1'b0;
          n_cmp++;
          if (bus.Y !== 16'h1C00) begin
            n_err++;
            $display("FAIL b2b_result: got Y=%h, expected 1c00", bus.Y);
          end
        end else begin
          extra++;
        end
      end
    end
    bus.START = 1'b0;
    n_cmp++;
    if (d1 !== 30 || d2 !== 60 || extra !== 0) begin
      n_err++;
      $display("FAIL b2b_timing: got DONE at %0d and %0d plus %0d extra, expected 30 and 60 and 0", d1, d2, extra);
    end
    n_cmp++;
    if (bus.BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got BUSY=%b, expected 0", bus.BUSY);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int n_done = 0;
    fill(0, 16'h0100, 16'h0100);
    @(negedge clk);
    bus.START = 1'b1;
    bus.BIAS  = 16'h0000;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.W_ADDR, bus.X_ADDR, bus.W_EN, bus.X_EN, bus.BUSY, bus.DONE, bus.Y, bus.SAT} !== 35'd0) begin
      n_err++;
      $display("FAIL midrun_reset_async: got addr=%0d en=%b busy=%b done=%b y=%h sat=%b, expected all 0",
               bus.W_ADDR, bus.W_EN, bus.BUSY, bus.DONE, bus.Y, bus.SAT);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.DONE === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done !== 0 || bus.BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_no_done: got %0d DONEs BUSY=%b, expected 0/0", n_done, bus.BUSY);
    end
    do_run(16'h0000, cyc);
    n_cmp++;
    if (cyc !== 29 || bus.Y !== 16'h1C00 || bus.SAT !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_rerun: got %0d cycles Y=%h SAT=%b, expected 29/1c00/0", cyc, bus.Y, bus.SAT);
    end
  endtask

  initial begin
    bus.START = 1'b0;
    bus.BIAS  = 16'h0000;
    test_reset();
    test_vectors();
    test_addr_sweep();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
